conv_window_buffer: RTL and testbench
=====================================

// Module: conv_window_buffer
// PURPOSE
//  Streaming sliding-window generator placed directly upstream of convolution_point.
//  Accepts a feature map one pixel per handshake, in raster order.
//  Stores K-1 full rows in line buffers plus a KxK shift window.
//  Emits every valid KxK map_block ('valid' convolution, stride 1) with a
//  valid/ready handshake so the convolution stage can stall it.
// PARAMETERS
//  BITWIDTH    4   pixel width in bits (two's complement, passed through unchanged)
//  K           5   window edge; window is KxK (convolution_point uses 5)
//  IMG_WIDTH   8   pixels per row; must be >= K
//  IMG_HEIGHT  8   rows per frame; must be >= K
// PORTS
//  clk        in   1                   rising-edge clock
//  rst_n      in   1                   asynchronous active-low reset
//  in_valid   in   1                   in_pixel/in_sof valid
//  in_ready   out  1                   block can accept a pixel this cycle
//  in_pixel   in   BITWIDTH            pixel data
//  in_sof     in   1                   start of frame; pixel is (row 0, col 0)
//  map_block  out  [K-1:0][K-1:0]xBW   window; [0][0]=top-left (oldest), [K-1][K-1]=newest
//  out_valid  out  1                   map_block holds a complete window
//  out_ready  in   1                   downstream accepts map_block
//  frame_done out  1                   one-cycle pulse after the last pixel of a frame is accepted
// BEHAVIOUR
//  - accept = in_valid & in_ready; in_ready = ~out_valid | out_ready (combinational)
//  - row/col counters: on accept, col++; at col==IMG_WIDTH-1, col->0 and row++;
//    at (IMG_HEIGHT-1, IMG_WIDTH-1), row,col->0 and frame_done=1 next cycle
//  - in_sof on accept: pixel is treated as (0,0) regardless of the counters;
//    counters advance from (0,0). A mid-frame SOF abandons the old frame with no
//    frame_done. Line buffer data from the old frame is never exposed.
//  - line buffers: K-1 rows x IMG_WIDTH; on accept at col c, read column c of every
//    row (oldest..newest), shift up one row, write in_pixel as newest
//  - window: on accept, shift all rows left one column; new right column =
//    {K-1 line buffer reads, in_pixel}
//  - out_valid <= 1 the cycle after an accept with row>=K-1 and col>=K-1 (latency 1);
//    map_block then covers rows row-K+1..row and cols col-K+1..col
//  - out_valid cleared when out_ready=1 and no window-producing accept in the same cycle;
//    a simultaneous consume+produce keeps out_valid=1 with the new window
//  - while out_valid & ~out_ready: map_block, out_valid and counters hold; in_ready=0
//  - windows per frame = (IMG_HEIGHT-K+1)*(IMG_WIDTH-K+1); no window spans a row wrap
//  - reset (async, any time): counters=0, out_valid=0, frame_done=0, map_block=0,
//    in_ready=1; line buffers need not be cleared
//  - no arithmetic on pixel data; bit-exact passthrough
// CONFIGURATION
//  CONV_WINDOW_POS_EN defined: adds ports
//    out_row out $clog2(IMG_HEIGHT) and out_col out $clog2(IMG_WIDTH), giving the
//    top-left position of map_block. Both are registered with map_block, reset to 0,
//    and held under stall.
//  not defined: these ports and their registers are absent; all other behaviour is identical.
// TESTING
//  1 8x8, K=5, pixel=(r*8+c)%16, out_ready=1 -> exactly 16 out_valid beats; first beat
//    [0][0]=0,[4][4]=4; last beat [4][4]=(63%16)=15; one frame_done pulse
//  2 All pixels 4'hF -> every map_block element is 4'hF; 16 windows
//  3 out_ready=0 for 3 cycles while out_valid -> map_block stable, in_ready=0,
//    no pixel dropped; window sequence identical to test 1
//  4 in_sof re-asserted on the 20th pixel -> no out_valid until the new frame's (4,4);
//    new-frame windows match test 1; no frame_done for the aborted frame
//  5 rst_n low mid-frame for 1 cycle -> out_valid=0 immediately; after release, a
//    fresh frame reproduces test 1
//  6 CONV_WINDOW_POS_EN -> (out_row,out_col): first beat (0,0), fifth beat (1,0),
//    last beat (3,3)

Source files
------------

// File: rtl/conv_window_buffer.sv
// conv_window_buffer: raster-order pixel stream to KxK sliding windows.
// Optional macro CONV_WINDOW_POS_EN adds out_row/out_col window position ports.
`timescale 1ns/1ps

module conv_window_buffer #(
  parameter int BITWIDTH   = 4,
  parameter int K          = 5,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [BITWIDTH-1:0]                 in_pixel,
  input  logic                                in_sof,
  output logic [K-1:0][K-1:0][BITWIDTH-1:0]   map_block,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                frame_done
`ifdef CONV_WINDOW_POS_EN
  ,
  output logic [$clog2(IMG_HEIGHT)-1:0]       out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]        out_col
`endif
);

  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);

  typedef logic [BITWIDTH-1:0] px_t;
  typedef logic [K-2:0][IMG_WIDTH-1:0][BITWIDTH-1:0] lb_t;
  typedef logic [K-1:0][K-1:0][BITWIDTH-1:0] win_t;

  // position counters
  logic [RW-1:0] row_q;
  logic [RW-1:0] row_d;
  logic [CW-1:0] col_q;
  logic [CW-1:0] col_d;

  // position of the pixel being accepted
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;

  logic          accept;
  logic          produce;
  logic          row_end;
  logic          col_end;

  // line buffers and window
  lb_t           lb_q;
  lb_t           lb_d;
  win_t          win_q;
  win_t          win_d;

  logic [K-2:0][BITWIDTH-1:0] lb_rd;
  logic [K-1:0][BITWIDTH-1:0] new_col;

  // output control
  logic          out_valid_q;
  logic          out_valid_d;
  logic          frame_done_q;
  logic          frame_done_d;

`ifdef CONV_WINDOW_POS_EN
  logic [RW-1:0] out_row_q;
  logic [RW-1:0] out_row_d;
  logic [CW-1:0] out_col_q;
  logic [CW-1:0] out_col_d;
`endif

  // Handshake: a held window blocks input until it is taken.
  always_comb begin
    in_ready = ~out_valid_q | out_ready;
    accept   = in_valid & in_ready;
  end

  // SOF forces the accepted pixel to (0,0) whatever the counters say.
  always_comb begin
    cur_row = row_q;
    cur_col = col_q;
    if (in_sof) begin
      cur_row = '0;
      cur_col = '0;
    end
  end

  // Edge detection and window-producing condition.
  always_comb begin
    row_end = (cur_row == ROW_LAST);
    col_end = (cur_col == COL_LAST);
    produce = accept
            & (cur_row >= ROW_MIN)
            & (cur_col >= COL_MIN);
  end

  // Raster counters with end-of-frame pulse.
  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    if (accept) begin
      if (col_end) begin
        col_d = '0;
        if (row_end) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = cur_row + RW'(1);
        end
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  // Line buffer column read (oldest row first).
  always_comb begin
    lb_rd = '0;
    for (int i = 0; i < K - 1; i++) begin
      lb_rd[i] = lb_q[i][cur_col];
    end
  end

  // Line buffer column shift-up with the new pixel as newest row.
  always_comb begin
    lb_d = lb_q;
    if (accept) begin
      for (int i = 0; i < K - 2; i++) begin
        lb_d[i][cur_col] = lb_q[i+1][cur_col];
      end
      lb_d[K-2][cur_col] = in_pixel;
    end
  end

  // New right-hand window column: stored rows above, live pixel below.
  always_comb begin
    new_col = '0;
    for (int i = 0; i < K - 1; i++) begin
      new_col[i] = lb_rd[i];
    end
    new_col[K-1] = in_pixel;
  end

  // Window slides left by one column on each accepted pixel.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
        win_d[i][K-1] = new_col[i];
      end
    end
  end

  // Valid is set by a producing accept, held while downstream stalls.
  always_comb begin
    out_valid_d = produce | (out_valid_q & ~out_ready);
  end

`ifdef CONV_WINDOW_POS_EN
  // Top-left position of the window being produced.
  always_comb begin
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    if (produce) begin
      out_row_d = cur_row - ROW_MIN;
      out_col_d = cur_col - COL_MIN;
    end
  end
`endif

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= '0;
      col_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Window and line buffer storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      lb_q  <= '0;
    end else begin
      win_q <= win_d;
      lb_q  <= lb_d;
    end
  end

`ifdef CONV_WINDOW_POS_EN
  // Window position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_row_q <= '0;
      out_col_q <= '0;
    end else begin
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
    end
  end
`endif

  // Output mapping.
  always_comb begin
    map_block  = win_q;
    out_valid  = out_valid_q;
    frame_done = frame_done_q;
`ifdef CONV_WINDOW_POS_EN
    out_row    = out_row_q;
    out_col    = out_col_q;
`endif
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// tb_conv_window_buffer: random-gap stream bench with a frame-image model.
// Expected windows are cut directly out of the accepted-pixel image.
`timescale 1ns/1ps

module tb_conv_window_buffer;

  localparam int BW = 4;
  localparam int K  = 5;
  localparam int W  = 8;
  localparam int H  = 8;

  typedef logic [K-1:0][K-1:0][BW-1:0] blk_t;
  typedef struct {
    blk_t blk;
    int   r;
    int   c;
  } exp_t;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [BW-1:0] in_pixel = '0;
  logic          in_sof = 0;
  blk_t          map_block;
  logic          out_valid;
  logic          out_ready = 1;
  logic          frame_done;
`ifdef CONV_WINDOW_POS_EN
  logic [2:0]    out_row;
  logic [2:0]    out_col;
`endif

  conv_window_buffer #(
    .BITWIDTH(BW), .K(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pixel(in_pixel),
    .in_sof(in_sof),
    .map_block(map_block),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_done(frame_done)
`ifdef CONV_WINDOW_POS_EN
    ,
    .out_row(out_row),
    .out_col(out_col)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model state
  int       mr = 0;
  int       mc = 0;
  logic [BW-1:0] img [H][W];
  exp_t     expq[$];
  blk_t     beats[$];
  blk_t     ref1[$];
  int       pos_r[$];
  int       pos_c[$];
  int       fd_cnt = 0;
  logic     fd_exp = 0;
  logic     stall_prev = 0;
  int       stall_cnt = 0;
  blk_t     prev_blk;
  int       rdy_mode = 0;
  int       stall_left = 0;

  // Compare and model update, away from the active edge.
  always @(negedge clk) begin : cmp
    exp_t w;
    if (!rst_n) begin
      expq.delete();
      mr = 0;
      mc = 0;
      fd_exp = 0;
      stall_prev = 0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      chk("frame_done", frame_done, fd_exp);
      if (frame_done) fd_cnt++;
      fd_exp = 0;
      chk("out_valid", out_valid, expq.size() != 0);
      if (stall_prev) begin
        stall_cnt++;
        chk("stall_hold", map_block, prev_blk);
        chk("stall_valid", out_valid, 1);
      end
      if (out_valid && expq.size() != 0) begin
        chk("map_block", map_block, expq[0].blk);
`ifdef CONV_WINDOW_POS_EN
        chk("out_row", out_row, expq[0].r);
        chk("out_col", out_col, expq[0].c);
`endif
      end
      stall_prev = out_valid && !out_ready;
      prev_blk = map_block;
      if (out_valid && out_ready) begin
        beats.push_back(map_block);
`ifdef CONV_WINDOW_POS_EN
        pos_r.push_back(int'(out_row));
        pos_c.push_back(int'(out_col));
`endif
        if (expq.size() != 0) void'(expq.pop_front());
      end
      if (in_valid && in_ready) begin
        if (in_sof) begin
          mr = 0;
          mc = 0;
        end
        img[mr][mc] = in_pixel;
        if (mr >= K - 1 && mc >= K - 1) begin
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              w.blk[i][j] = img[mr-K+1+i][mc-K+1+j];
          w.r = mr - K + 1;
          w.c = mc - K + 1;
          expq.push_back(w);
        end
        if (mr == H - 1 && mc == W - 1) fd_exp = 1;
        mc++;
        if (mc == W) begin
          mc = 0;
          mr++;
          if (mr == H) mr = 0;
        end
      end
    end
  end

  // Downstream readiness pattern.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (stall_left > 0 && out_valid) begin
          out_ready = 0;
          stall_left--;
        end else begin
          out_ready = 1;
        end
      end
      default: out_ready = 1;
    endcase
  end

  task automatic send_px(input logic [BW-1:0] px, input logic sof,
                         input int gap);
    int n;
    logic acc;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1;
    in_pixel = px;
    in_sof = sof;
    n = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got no accept expected accept");
        break;
      end
    end
    in_valid = 0;
    in_sof = 0;
  endtask

  // mode 0: (r*8+c)%16, mode 1: all ones, mode 2: random
  task automatic send_frame(input int mode, input int npx, input int gapmax);
    int r;
    int c;
    logic [BW-1:0] px;
    for (int p = 0; p < npx; p++) begin
      r = p / W;
      c = p % W;
      case (mode)
        0: px = BW'((r * 8 + c) % 16);
        1: px = '1;
        default: px = BW'($urandom);
      endcase
      send_px(px, p == 0, gapmax > 0 ? $urandom_range(0, gapmax) : 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 || out_valid) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL drain_timeout: got pending expected empty");
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic cmp_ref(input string nm);
    chk({nm, "_count"}, beats.size(), ref1.size());
    for (int i = 0; i < beats.size() && i < ref1.size(); i++)
      chk({nm, "_beat"}, beats[i], ref1[i]);
  endtask

  task automatic clear_log();
    beats.delete();
    pos_r.delete();
    pos_c.delete();
    fd_cnt = 0;
    stall_cnt = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    blk_t b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_map_block", map_block, 0);
    @(negedge clk);
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;

    // 1: ramp pattern, always ready, random input gaps
    clear_log();
    send_frame(0, 64, 2);
    drain();
    chk("t1_beats", beats.size(), 16);
    chk("t1_frame_done", fd_cnt, 1);
    if (beats.size() == 16) begin
      b = beats[0];
      chk("t1_first_00", b[0][0], 0);
      chk("t1_first_44", b[4][4], 4);
      b = beats[4];
      chk("t1_fifth_00", b[0][0], 8);
      b = beats[15];
      chk("t1_last_44", b[4][4], 15);
      chk("t1_last_00", b[0][0], 3 * 8 % 16 + 3);
    end
`ifdef CONV_WINDOW_POS_EN
    if (pos_r.size() == 16) begin
      chk("t6_first_pos", {pos_r[0], pos_c[0]}, {32'd0, 32'd0});
      chk("t6_fifth_pos", {pos_r[4], pos_c[4]}, {32'd1, 32'd0});
      chk("t6_last_pos", {pos_r[15], pos_c[15]}, {32'd3, 32'd3});
    end
`endif
    ref1 = beats;

    // 2: all ones
    clear_log();
    send_frame(1, 64, 1);
    drain();
    chk("t2_beats", beats.size(), 16);
    foreach (beats[i]) chk("t2_all_f", beats[i], {(K*K*BW){1'b1}});

    // 3: stall three cycles while a window is held
    clear_log();
    rdy_mode = 2;
    stall_left = 3;
    send_frame(0, 64, 0);
    drain();
    rdy_mode = 0;
    chk("t3_stalled", stall_cnt >= 3, 1);
    cmp_ref("t3");

    // 4: SOF restarts on the 20th pixel
    clear_log();
    send_frame(0, 19, 1);
    send_frame(0, 64, 1);
    drain();
    chk("t4_frame_done", fd_cnt, 1);
    cmp_ref("t4");

    // 5: async reset mid-frame while a window is held
    clear_log();
    send_frame(0, 37, 0);
    @(negedge clk);
    chk("t5_pre_valid", out_valid, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_block", map_block, 0);
    @(negedge clk);
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
    clear_log();
    send_frame(0, 64, 1);
    drain();
    chk("t5_frame_done", fd_cnt, 1);
    cmp_ref("t5");

    // 7: random pixels, random readiness, two frames
    clear_log();
    rdy_mode = 1;
    send_frame(2, 64, 3);
    send_frame(2, 64, 0);
    rdy_mode = 0;
    drain();
    chk("t7_beats", beats.size(), 32);
    chk("t7_frame_done", fd_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
